// File: rtl/bch_pkg.sv
// Shared types, generator constants and a reference parity model for the BCH encoder.
package bch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  typedef enum logic {
    LFSR_DIVIDE = 1'b0,
    LFSR_SHIFT  = 1'b1
  } lfsr_mode_t;

  localparam logic [12:0] BCH63_51_G = 13'h1539;
  localparam logic [6:0]  BCH63_57_G = 7'h43;

  localparam int unsigned MAX_W = 64;

  // Remainder of x^r * m(x) mod g(x); msg[len-1] is the highest-order coefficient.
  function automatic logic [MAX_W-1:0] bch_parity(input logic [MAX_W-1:0] msg,
                                                  input int unsigned len,
                                                  input logic [MAX_W-1:0] gpoly,
                                                  input int unsigned r);
    logic [MAX_W-1:0] rem;
    logic [MAX_W-1:0] mask;
    logic             fb;
    rem  = '0;
    mask = (MAX_W'(1) << r) - MAX_W'(1);
    for (int i = int'(len) - 1; i >= 0; i--) begin
      fb  = msg[i[5:0]] ^ rem[6'(r - 1)];
      rem = ((rem << 1) ^ (fb ? gpoly : '0)) & mask;
    end
    return rem;
  endfunction

endpackage

// File: rtl/bch_lfsr.sv
// Parity register: divides the message by g(x), then shifts the remainder out MSB first.
module bch_lfsr
  import bch_pkg::*;
#(
  parameter int unsigned R        = 12,
  parameter logic [R:0]  GEN_POLY = BCH63_51_G
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  lfsr_mode_t mode,
  input  logic       din,
  input  logic       clr,
  output logic [R-1:0] lfsr,
  output logic       msb
);

  logic [R-1:0] r_lfsr;
  logic [R-1:0] w_next;
  logic         w_fb;

  assign lfsr = r_lfsr;
  assign msb  = r_lfsr[R-1];

  // Next value: plain left shift, with the generator folded in while dividing.
  always_comb begin
    w_fb   = din ^ r_lfsr[R-1];
    w_next = {r_lfsr[R-2:0], 1'b0};
    if (mode == LFSR_DIVIDE && w_fb) begin
      w_next = w_next ^ GEN_POLY[R-1:0];
    end
  end

  // Remainder register; clear wins over update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= '0;
    end else if (clr) begin
      r_lfsr <= '0;
    end else if (en) begin
      r_lfsr <= w_next;
    end
  end

endmodule

// File: rtl/bch_stream_encoder.sv
// Serial systematic BCH encoder: message bits pass through, then N-K parity bits follow.
module bch_stream_encoder
  import bch_pkg::*;
#(
  parameter int unsigned  N        = 63,
  parameter int unsigned  K        = 51,
  parameter logic [N-K:0] GEN_POLY = BCH63_51_G,
  localparam int unsigned LW       = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] msg_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_data,
  output logic          m_last,
  output logic [N-1:0]  m_word,
  output logic          m_word_valid,
  output logic          busy
);

  localparam int unsigned R  = N - K;
  localparam int unsigned PW = $clog2(R + 1);

  state_t      r_state;
  state_t      w_state_next;

  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;
  logic [PW-1:0] r_pcnt;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_m_word;
  logic          r_m_valid;
  logic          r_m_data;
  logic          r_m_last;
  logic          r_m_word_valid;

  logic          w_free;
  logic          w_accept;
  logic          w_par_load;
  logic          w_last_par;
  logic [LW-1:0] w_eff_len;
  logic          w_lfsr_en;
  logic          w_lfsr_clr;
  lfsr_mode_t    w_lfsr_mode;
  logic [R-1:0]  w_lfsr;
  logic          w_lfsr_msb;

  assign w_free     = !r_m_valid || m_ready;
  assign s_ready    = (r_state == IDLE || r_state == DATA) && w_free;
  assign w_accept   = s_valid && s_ready;
  assign w_eff_len  = (msg_len == '0 || msg_len > LW'(K)) ? LW'(K) : msg_len;
  assign w_par_load = (r_state == PARITY) && w_free;
  assign w_last_par = w_par_load && (r_pcnt == PW'(R - 1));

  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign m_last       = r_m_last;
  assign m_word       = r_m_word;
  assign m_word_valid = r_m_word_valid;
  assign busy         = (r_state != IDLE);

  bch_lfsr #(
    .R        (R),
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (w_lfsr_en),
    .mode (w_lfsr_mode),
    .din  (s_data),
    .clr  (w_lfsr_clr),
    .lfsr (w_lfsr),
    .msb  (w_lfsr_msb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and parity-register control.
  always_comb begin
    w_state_next = r_state;
    w_lfsr_en    = 1'b0;
    w_lfsr_clr   = 1'b0;
    w_lfsr_mode  = LFSR_DIVIDE;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_lfsr_en    = 1'b1;
          w_state_next = (w_eff_len == LW'(1)) ? PARITY : DATA;
        end
      end
      DATA: begin
        if (w_accept) begin
          w_lfsr_en = 1'b1;
          if (r_cnt == r_len - LW'(1)) begin
            w_state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (w_free) begin
          w_lfsr_en   = 1'b1;
          w_lfsr_mode = LFSR_SHIFT;
          if (r_pcnt == PW'(R - 1)) begin
            w_lfsr_clr   = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output register, counters and codeword accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid      <= 1'b0;
      r_m_data       <= 1'b0;
      r_m_last       <= 1'b0;
      r_m_word       <= '0;
      r_m_word_valid <= 1'b0;
      r_acc          <= '0;
      r_len          <= '0;
      r_cnt          <= '0;
      r_pcnt         <= '0;
    end else begin
      r_m_word_valid <= 1'b0;
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_data;
        r_m_last  <= 1'b0;
        r_pcnt    <= '0;
        if (r_state == IDLE) begin
          r_acc <= N'(s_data);
          r_len <= w_eff_len;
          r_cnt <= LW'(1);
        end else begin
          r_acc <= {r_acc[N-2:0], s_data};
          r_cnt <= r_cnt + LW'(1);
        end
      end else if (w_par_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_lfsr_msb;
        r_acc     <= {r_acc[N-2:0], w_lfsr_msb};
        if (w_last_par) begin
          r_m_last       <= 1'b1;
          r_m_word       <= {r_acc[N-2:0], w_lfsr_msb};
          r_m_word_valid <= 1'b1;
          r_pcnt         <= '0;
          r_cnt          <= '0;
          r_len          <= '0;
        end else begin
          r_m_last <= 1'b0;
          r_pcnt   <= r_pcnt + PW'(1);
        end
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  // Between frames the remainder register must already be empty.
  always_ff @(posedge clk) begin
    if (!rst && r_state == IDLE) begin
      assert (w_lfsr == '0);
    end
  end

endmodule

// File: tb/tb_bch_stream_encoder.sv
// Directed bench for bch_stream_encoder (63,51) and a (63,57) instance.
module tb_bch_stream_encoder;
  import bch_pkg::*;

  localparam int unsigned R      = 12;
  localparam int          BUDGET = 60000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  msg_len;
  logic        s_valid, s_ready, s_data;
  logic        m_valid, m_ready, m_data, m_last;
  logic [62:0] m_word;
  logic        m_word_valid, busy;

  logic [5:0]  b_msg_len;
  logic        b_s_valid, b_s_ready, b_s_data;
  logic        b_m_valid, b_m_ready, b_m_data, b_m_last;
  logic [62:0] b_m_word;
  logic        b_m_word_valid, b_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] q_msg[$];
  logic [63:0] q_exp[$];
  int          q_len[$];
  int          q_eff[$];

  always #5 clk = ~clk;

  bch_stream_encoder u_dut (
    .clk(clk), .rst(rst), .msg_len(msg_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_word(m_word), .m_word_valid(m_word_valid), .busy(busy)
  );

  bch_stream_encoder #(.N(63), .K(57), .GEN_POLY(BCH63_57_G)) u_dut57 (
    .clk(clk), .rst(rst), .msg_len(b_msg_len),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .m_word(b_m_word), .m_word_valid(b_m_word_valid), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [63:0] msg, input int field, input int eff);
    logic [63:0] m;
    m = msg & ((64'd1 << eff) - 64'd1);
    q_msg.push_back(m);
    q_len.push_back(field);
    q_eff.push_back(eff);
    q_exp.push_back((m << R) | bch_parity(m, eff, 64'(BCH63_51_G), R));
  endtask

  // Streams all queued frames through the default DUT and checks each codeword.
  task automatic run_stream(input int rdy_pct, input int vld_pct, output int span);
    int nfr, sf, sb, rf, rb, cyc, first, lastc;
    logic [63:0] acc, tmp;
    logic early, in_f, out_f, od, ol;
    logic [63:0] words[$];
    nfr = q_msg.size();
    sf = 0; sb = 0; rf = 0; rb = 0; cyc = 0; first = -1; lastc = -1;
    acc = '0; early = 1'b0;
    while (rf < nfr && cyc < BUDGET) begin
      @(negedge clk);
      m_ready = ($urandom_range(99) < rdy_pct);
      if (sf < nfr) begin
        tmp     = q_msg[sf];
        msg_len = 6'(q_len[sf]);
        s_data  = tmp[q_eff[sf] - 1 - sb];
        s_valid = ($urandom_range(99) < vld_pct);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (m_word_valid) words.push_back(64'(m_word));
      in_f  = s_valid && s_ready;
      out_f = m_valid && m_ready;
      od    = m_data;
      ol    = m_last;
      @(posedge clk);
      cyc++;
      if (in_f) begin
        sb++;
        if (sb == q_eff[sf]) begin
          sf++;
          sb = 0;
        end
      end
      if (out_f) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        acc = {acc[62:0], od};
        rb++;
        if (rb == q_eff[rf] + int'(R)) begin
          check("stream", acc, q_exp[rf]);
          check("m_last_final", 64'(ol), 64'd1);
          check("m_last_early", 64'(early), 64'd0);
          check("divisible", bch_parity(acc, q_eff[rf] + R, 64'(BCH63_51_G), R), 64'd0);
          rf++;
          rb = 0;
          acc = '0;
          early = 1'b0;
        end else if (ol) begin
          early = 1'b1;
        end
      end
    end
    check("stream_timeout", 64'(cyc < BUDGET), 64'd1);
    check("word_pulses", 64'(words.size()), 64'(nfr));
    for (int i = 0; i < words.size() && i < nfr; i++) begin
      check("m_word", words[i], q_exp[i]);
    end
    span = lastc - first + 1;
    q_msg.delete(); q_exp.delete(); q_len.delete(); q_eff.delete();
  endtask

  initial begin
    int span;
    logic [63:0] acc;
    logic [63:0] bword;
    int sent, got, lastpos, cyc;
    logic inf, outf, od, ol;

    rst = 1'b1; msg_len = '0; s_valid = 1'b0; s_data = 1'b0; m_ready = 1'b0;
    b_msg_len = '0; b_s_valid = 1'b0; b_s_data = 1'b0; b_m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_word", 64'(m_word), 64'd0);
    check("rst_m_word_valid", 64'(m_word_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);

    // All-zero full-length frame.
    add_frame(64'd0, 51, 51);
    run_stream(100, 100, span);
    check("zero_span", 64'(span), 64'd63);

    // L = 1 frame with message bit 1; s_ready must stay low through parity.
    @(negedge clk);
    msg_len = 6'd1; s_data = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    acc = '0;
    for (int c = 0; c < int'(R); c++) begin
      @(negedge clk);
      #1;
      check("s_ready_parity", 64'(s_ready), 64'd0);
      acc = {acc[62:0], m_data};
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    acc = {acc[62:0], m_data};
    check("l1_stream", acc, 64'h1539);
    check("l1_m_last", 64'(m_last), 64'd1);
    check("l1_word_valid", 64'(m_word_valid), 64'd1);
    check("l1_m_word", 64'(m_word), 64'h1539);
    check("l1_s_ready_idle", 64'(s_ready), 64'd1);
    @(posedge clk);
    repeat (2) @(posedge clk);

    // Random full-length frames, msg_len 0 / 51 / >K all meaning 51.
    for (int i = 0; i < 200; i++) begin
      add_frame({$urandom, $urandom}, (i % 3 == 0) ? 0 : (i % 3 == 1) ? 51 : int'($urandom_range(52, 63)), 51);
    end
    run_stream(60, 80, span);

    // Back-to-back frames: 51, 20, then 0 (meaning 51).
    add_frame({$urandom, $urandom}, 51, 51);
    add_frame({$urandom, $urandom}, 20, 20);
    add_frame({$urandom, $urandom}, 0, 51);
    run_stream(100, 100, span);
    check("b2b_span", 64'(span), 64'd158);

    // Reset in the middle of a frame.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      msg_len = 6'd51; s_data = 1'($urandom); s_valid = 1'b1; m_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_m_data", 64'(m_data), 64'd0);
    check("mid_rst_m_last", 64'(m_last), 64'd0);
    check("mid_rst_m_word", 64'(m_word), 64'd0);
    check("mid_rst_word_valid", 64'(m_word_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    add_frame({$urandom, $urandom}, 51, 51);
    run_stream(100, 100, span);

    // (63,57) instance: only the final message bit set.
    sent = 0; got = 0; lastpos = -1; cyc = 0; acc = '0; bword = '0;
    while (got < 63 && cyc < 400) begin
      @(negedge clk);
      b_m_ready = 1'b1;
      b_msg_len = 6'd57;
      b_s_valid = (sent < 57);
      b_s_data  = (sent == 56);
      #1;
      if (b_m_word_valid) bword = 64'(b_m_word);
      inf  = b_s_valid && b_s_ready;
      outf = b_m_valid && b_m_ready;
      od   = b_m_data;
      ol   = b_m_last;
      @(posedge clk);
      cyc++;
      if (inf) sent++;
      if (outf) begin
        acc = {acc[62:0], od};
        got++;
        if (ol && lastpos < 0) lastpos = got;
      end
    end
    @(negedge clk);
    b_s_valid = 1'b0;
    #1;
    if (b_m_word_valid) bword = 64'(b_m_word);
    check("k57_timeout", 64'(cyc < 400), 64'd1);
    check("k57_parity", 64'(acc[5:0]), 64'h03);
    check("k57_stream", acc, 64'h43);
    check("k57_last_pos", 64'(lastpos), 64'd63);
    check("k57_m_word", bword, 64'h43);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
